fifo_drain_pacer: RTL and testbench
===================================

FIFO_DRAIN_PACER -- requirements
Module: fifo_drain_pacer

Interface
REQ-001 Parameter DATA_W, default 8: FIFO data width in bits.
REQ-002 Parameter RD_LAT, default 1: FIFO read latency in cycles, rd_en to valid rd_data; legal range 1..3.
REQ-003 clk_in  input  1: single system clock; all state is clocked on its rising edge.
REQ-004 reset_n  input  1: reset, asynchronous and active-low.
REQ-005 tick_clk  input  1: divided clock from the upstream clock divider; treated as a level and sampled on clk_in only.
REQ-006 enable  input  1: 1 = pacing active; 0 = no new reads are started.
REQ-007 fifo_empty  input  1: FIFO empty flag.
REQ-008 fifo_rd_data  input  DATA_W: FIFO read data, valid RD_LAT cycles after fifo_rd_en.
REQ-009 fifo_rd_en  output  1: one-cycle FIFO pop request.
REQ-010 data_out  output  DATA_W: last popped word, held until the next pop.
REQ-011 data_valid  output  1: one-cycle pulse in the cycle data_out updates.
REQ-012 busy  output  1: high in any state other than IDLE.

Function
REQ-013 tick_clk passes through a 2-flop synchronizer; a rising edge is detected on a third flop (sync=1, prev=0), giving 3 cycles of latency from the tick_clk edge.
REQ-014 FSM states: IDLE, READ, WAIT, CAPTURE.
REQ-015 IDLE -> READ on a detected edge when enable=1 and fifo_empty=0; on an edge with fifo_empty=1 or enable=0, the FSM stays in IDLE and no read is issued.
REQ-016 READ lasts exactly one cycle with fifo_rd_en=1; fifo_rd_en is 0 in every other state.
REQ-017 WAIT counts RD_LAT-1 cycles (0 cycles if RD_LAT=1) and then goes to CAPTURE.
REQ-018 CAPTURE registers fifo_rd_data into data_out, pulses data_valid for one cycle, and returns to IDLE.
REQ-019 Latency from the detected edge: fifo_rd_en on the next cycle; data_valid RD_LAT+1 cycles after fifo_rd_en.
REQ-020 At most one pop per detected edge; an edge detected while not in IDLE is dropped and is not queued.
REQ-021 enable falling mid-sequence does not abort it; the sequence in flight completes.
REQ-022 fifo_empty is evaluated only in IDLE; a change during READ/WAIT/CAPTURE is ignored.
REQ-023 data_out holds its value indefinitely between pops, including while enable=0.

Reset
REQ-024 reset_n low asynchronously forces: FSM=IDLE, synchronizer/edge flops=0, fifo_rd_en=0, data_valid=0, data_out=0, busy=0, WAIT counter=0, and (if compiled in) all stats counters=0.
REQ-025 Reset asserted mid-sequence abandons the sequence; no data_valid pulse follows reset release.
REQ-026 After reset release, a tick_clk already high produces no edge until it goes low and then high again.

Configuration
REQ-027 Macro PACER_STATS_EN: when defined, adds outputs pop_count[15:0] (pops completed) and miss_count[15:0] (edges dropped per REQ-015 empty case or REQ-020); both saturate at 16'hFFFF.
REQ-028 When PACER_STATS_EN is not defined, those ports and counters do not exist and all other behaviour is identical.

Verification
REQ-029 FIFO holds 8'hA5, enable=1, tick_clk rises -> fifo_rd_en pulse on edge-detect+1, data_out=8'hA5 with data_valid 2 cycles later (RD_LAT=1).
REQ-030 FIFO empty, 3 tick_clk rising edges -> no fifo_rd_en; miss_count=3 and data_out unchanged with PACER_STATS_EN.
REQ-031 RD_LAT=3, word 8'h3C -> data_valid exactly 4 cycles after fifo_rd_en, data_out=8'h3C.
REQ-032 tick_clk edges 2 cycles apart during a sequence -> second edge dropped; exactly one pop; miss_count=1.
REQ-033 reset_n pulled low in the cycle after fifo_rd_en -> all outputs 0 immediately; no data_valid after release.
REQ-034 Counter saturation: force pop_count to 16'hFFFE, perform 3 pops -> pop_count=16'hFFFF.

Source files
------------

// File: rtl/fifo_drain_pacer.sv
`timescale 1ns/1ps
// fifo_drain_pacer: pops one FIFO word per detected rising edge of tick_clk.
// Build option: define PACER_STATS_EN to add saturating pop_count / miss_count outputs.
module fifo_drain_pacer #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              tick_clk,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
`ifdef PACER_STATS_EN
    ,
    output logic [15:0]       pop_count,
    output logic [15:0]       miss_count
`endif
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, CAPTURE} state_t;

    // Extra WAIT cycles beyond READ so CAPTURE lands exactly when read data is valid.
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t     state;
    logic [1:0] wait_cnt;
    logic       tick_meta;
    logic       tick_sync;
    logic       tick_prev;
    logic [2:0] hist_fill;
    logic       tick_edge;

    // hist_fill suppresses edges until tick_prev holds a genuine post-reset sample,
    // so a tick_clk already high at reset release must first go low.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            tick_meta <= 1'b0;
            tick_sync <= 1'b0;
            tick_prev <= 1'b0;
            hist_fill <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let each stage capture the previous stage's pre-edge value.
            tick_meta <= tick_clk;
            tick_sync <= tick_meta;
            tick_prev <= tick_sync;
            hist_fill <= {hist_fill[1:0], 1'b1};
        end
    end

    assign tick_edge = tick_sync & ~tick_prev & hist_fill[2];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            fifo_rd_en <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each state only has to raise them.
            fifo_rd_en <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_edge && enable && !fifo_empty) begin
                        state      <= READ;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                READ: begin
                    if (RD_LAT == 1) begin
                        state <= CAPTURE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) state <= CAPTURE;
                    else wait_cnt <= wait_cnt - 2'd1;
                end
                CAPTURE: begin
                    data_out   <= fifo_rd_data;
                    data_valid <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PACER_STATS_EN
    logic [15:0] pop_cnt;
    logic [15:0] miss_cnt;

    // A miss is an edge that arrives mid-sequence or finds the FIFO empty.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pop_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
        end else begin
            if (state == CAPTURE && pop_cnt != 16'hFFFF) pop_cnt <= pop_cnt + 16'd1;
            if (tick_edge && (state != IDLE || fifo_empty) && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end

    assign pop_count  = pop_cnt;
    assign miss_count = miss_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain_pacer.sv
`timescale 1ns/1ps
// Scoreboard bench: two pacers (RD_LAT=1 and RD_LAT=3) share tick/enable/reset;
// a time-based reference model predicts pops, a negedge monitor compares.
module tb_fifo_drain_pacer;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } dv_item_t;

    logic       clk_in  = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick_clk = 1'b0;
    logic       enable  = 1'b0;
    logic       fifo_empty   [2] = '{1'b1, 1'b1};
    logic [7:0] fifo_rd_data [2] = '{8'h00, 8'h00};
    logic       fifo_rd_en   [2];
    logic [7:0] data_out     [2];
    logic       data_valid   [2];
    logic       busy         [2];
`ifdef PACER_STATS_EN
    logic [15:0] pop_count  [2];
    logic [15:0] miss_count [2];
`endif

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] fifo_q   [2][$];
    logic [7:0] pipe     [2][4];
    int         rd_exp   [2][$];
    dv_item_t   dv_exp   [2][$];
    int         acc      [2];
    logic [7:0] exp_dout [2];
    int         exp_pops [2];
    int         exp_miss [2];
    logic       tick_hist[$];

    always #5 clk_in = ~clk_in;

    fifo_drain_pacer #(.DATA_W(8), .RD_LAT(1)) u_dut0 (
        .clk_in(clk_in), .reset_n(reset_n), .tick_clk(tick_clk), .enable(enable),
        .fifo_empty(fifo_empty[0]), .fifo_rd_data(fifo_rd_data[0]), .fifo_rd_en(fifo_rd_en[0]),
        .data_out(data_out[0]), .data_valid(data_valid[0]), .busy(busy[0])
`ifdef PACER_STATS_EN
        , .pop_count(pop_count[0]), .miss_count(miss_count[0])
`endif
    );

    fifo_drain_pacer #(.DATA_W(8), .RD_LAT(3)) u_dut1 (
        .clk_in(clk_in), .reset_n(reset_n), .tick_clk(tick_clk), .enable(enable),
        .fifo_empty(fifo_empty[1]), .fifo_rd_data(fifo_rd_data[1]), .fifo_rd_en(fifo_rd_en[1]),
        .data_out(data_out[1]), .data_valid(data_valid[1]), .busy(busy[1])
`ifdef PACER_STATS_EN
        , .pop_count(pop_count[1]), .miss_count(miss_count[1])
`endif
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Reference model: an edge is a 0->1 step in the sampled tick level, seen three samples
    // later; a pacer accepting at cycle a is occupied until cycle a+L+1 inclusive.
    always @(posedge clk_in) begin
        logic rise;
        cyc++;
        if (!reset_n) begin
            tick_hist.delete();
        end else begin
            tick_hist.push_back(tick_clk);
            if (tick_hist.size() > 4) void'(tick_hist.pop_front());
            rise = (tick_hist.size() == 4) && tick_hist[1] && !tick_hist[0];
            if (rise) begin
                for (int i = 0; i < 2; i++) begin
                    if (cyc > acc[i] && cyc <= acc[i] + lat(i) + 1) begin
                        exp_miss[i] = sat16(exp_miss[i]);
                    end else if (fifo_q[i].size() == 0) begin
                        exp_miss[i] = sat16(exp_miss[i]);
                    end else if (enable) begin
                        dv_item_t d;
                        d.cyc  = cyc + lat(i) + 1;
                        d.data = fifo_q[i][0];
                        acc[i] = cyc;
                        rd_exp[i].push_back(cyc);
                        dv_exp[i].push_back(d);
                    end
                end
            end
        end
    end

    // Monitor: registered outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk_in) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                if (fifo_rd_en[i] || (rd_exp[i].size() > 0 && rd_exp[i][0] == cyc)) begin
                    if (rd_exp[i].size() == 0) begin
                        check($sformatf("rd_en_unexpected[%0d]", i), 32'(fifo_rd_en[i]), 32'd0);
                    end else begin
                        int e;
                        e = rd_exp[i].pop_front();
                        check($sformatf("rd_en_cycle[%0d]", i), fifo_rd_en[i] ? cyc : -1, e);
                    end
                end
                if (data_valid[i] || (dv_exp[i].size() > 0 && dv_exp[i][0].cyc == cyc)) begin
                    if (dv_exp[i].size() == 0) begin
                        check($sformatf("dv_unexpected[%0d]", i), 32'(data_valid[i]), 32'd0);
                    end else begin
                        dv_item_t d;
                        d = dv_exp[i].pop_front();
                        exp_dout[i] = d.data;
                        exp_pops[i] = sat16(exp_pops[i]);
                        check($sformatf("dv_cycle[%0d]", i), data_valid[i] ? cyc : -1, d.cyc);
                    end
                end
                check($sformatf("data_out[%0d]", i), 32'(data_out[i]), 32'(exp_dout[i]));
                check($sformatf("busy[%0d]", i), 32'(busy[i]),
                      32'(cyc >= acc[i] && cyc <= acc[i] + lat(i)));
`ifdef PACER_STATS_EN
                check($sformatf("pop_count[%0d]", i), 32'(pop_count[i]), exp_pops[i]);
                check($sformatf("miss_count[%0d]", i), 32'(miss_count[i]), exp_miss[i]);
`endif
            end
        end
    end

    // FIFO model: a popped word reaches fifo_rd_data RD_LAT cycles after the pop is seen;
    // other cycles carry junk so a mistimed capture shows up.
    task automatic fifo_step();
        for (int i = 0; i < 2; i++) begin
            for (int k = 3; k > 0; k--) pipe[i][k] = pipe[i][k-1];
            if (fifo_rd_en[i] && fifo_q[i].size() > 0) pipe[i][0] = fifo_q[i].pop_front();
            else pipe[i][0] = 8'($urandom);
            fifo_rd_data[i] = pipe[i][lat(i)];
            fifo_empty[i]   = (fifo_q[i].size() == 0);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk_in);
            fifo_step();
        end
    endtask

    task automatic push_word(input int i, input logic [7:0] w);
        fifo_q[i].push_back(w);
        fifo_empty[i] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_rd_en[%0d]", i), 32'(fifo_rd_en[i]), 32'd0);
            check($sformatf("rst_dv[%0d]", i), 32'(data_valid[i]), 32'd0);
            check($sformatf("rst_data_out[%0d]", i), 32'(data_out[i]), 32'd0);
            check($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
`ifdef PACER_STATS_EN
            check($sformatf("rst_pop_count[%0d]", i), 32'(pop_count[i]), 32'd0);
            check($sformatf("rst_miss_count[%0d]", i), 32'(miss_count[i]), 32'd0);
`endif
            rd_exp[i].delete();
            dv_exp[i].delete();
            acc[i]      = -100;
            exp_dout[i] = 8'h00;
            exp_pops[i] = 0;
            exp_miss[i] = 0;
        end
        tick_hist.delete();
        cycles(3);
        reset_n = 1'b1;
    endtask

    task automatic tick_pulse(input int lo, input int hi);
        tick_clk = 1'b0;
        cycles(lo);
        tick_clk = 1'b1;
        cycles(hi);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 2; i++) begin
            acc[i] = -100;
            exp_dout[i] = 8'h00;
            exp_pops[i] = 0;
            exp_miss[i] = 0;
            for (int k = 0; k < 4; k++) pipe[i][k] = 8'h00;
        end
        #1;
        do_reset();
        enable = 1'b1;

        // Single pop with known words on both latencies.
        push_word(0, 8'hA5);
        push_word(1, 8'h3C);
        tick_pulse(3, 6);
        cycles(6);

        // Empty FIFOs: three edges, no reads.
        repeat (3) tick_pulse(3, 3);
        cycles(8);

        // Two edges two cycles apart: second one dropped.
        push_word(0, 8'h11); push_word(0, 8'h22);
        push_word(1, 8'h33); push_word(1, 8'h44);
        tick_clk = 1'b0; cycles(3);
        tick_clk = 1'b1; cycles(1);
        tick_clk = 1'b0; cycles(1);
        tick_clk = 1'b1; cycles(1);
        tick_clk = 1'b0; cycles(10);

        // Edge with enable low: nothing happens, data_out held.
        enable = 1'b0;
        tick_pulse(3, 3);
        cycles(6);

        // Enable drops right after acceptance: sequence still completes.
        enable = 1'b1;
        tick_clk = 1'b0; cycles(3);
        tick_clk = 1'b1; cycles(3);
        enable = 1'b0;
        cycles(6);
        enable = 1'b1;

        // Reset the cycle after fifo_rd_en, tick_clk held high across release.
        push_word(0, 8'h5A); push_word(1, 8'hC3);
        tick_clk = 1'b0; cycles(3);
        tick_clk = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            cycles(1);
            if (fifo_rd_en[0]) found = 1'b1;
        end
        check("rd_en_before_reset", 32'(found), 32'd1);
        @(posedge clk_in);
        #2;
        do_reset();
        cycles(8);
        tick_pulse(3, 8);

`ifdef PACER_STATS_EN
        // Saturation of pop_count on instance 0.
        tick_clk = 1'b0;
        cycles(2);
        @(posedge clk_in);
        #2;
        force u_dut0.pop_cnt = 16'hFFFE;
        #1;
        release u_dut0.pop_cnt;
        exp_pops[0] = 16'hFFFE;
        for (int n = 0; n < 3; n++) begin
            push_word(0, 8'(8'h70 + n));
            tick_pulse(3, 8);
        end
        cycles(4);
        check("pop_count_saturated", 32'(pop_count[0]), 32'hFFFF);
`endif

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 2500; n++) begin
            cycles(1);
            if ($urandom_range(0, 2) == 0) begin
                int i;
                i = int'($urandom_range(0, 1));
                if (fifo_q[i].size() < 6) push_word(i, 8'($urandom));
            end
            if ($urandom_range(0, 4) == 0) tick_clk = ~tick_clk;
            if ($urandom_range(0, 29) == 0) enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 799) == 0) do_reset();
        end

        tick_clk = 1'b0;
        cycles(12);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rd_outstanding[%0d]", i), rd_exp[i].size(), 0);
            check($sformatf("dv_outstanding[%0d]", i), dv_exp[i].size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
